// File: rtl/rrat.sv
// rtl/rrat.sv - retirement RAT: architected ARN->PRN map for two threads, PRN release and mispredict recovery pulses
module rrat #(
  parameter int AR_SIZE  = 32,
  parameter int PR_SIZE  = 64,
  parameter int PR_BITS  = 6,
  parameter int ZERO_REG = 31
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [1:0]                              commit_valid,
  input  logic [1:0]                              commit_thread_id,
  input  logic [1:0][4:0]                         commit_ARN_dest,
  input  logic [1:0][PR_BITS-1:0]                 commit_PRN_dest,
  input  logic [1:0]                              commit_mispredict,
  output logic [1:0][AR_SIZE-1:0][PR_BITS-1:0]    RRAT_arr,
  output logic [1:0]                              free_valid,
  output logic [1:0][PR_BITS-1:0]                 free_PRN,
  output logic                                    mispredict_thread_0,
  output logic                                    mispredict_thread_1
);

  localparam logic [PR_BITS-1:0] NO_PRN  = PR_BITS'(PR_SIZE - 1);
  localparam logic [4:0]         ZERO_AR = 5'(ZERO_REG);

  logic               kill1;
  logic [1:0]         live;
  logic [1:0]         eff;
  logic               same_dest;
  logic [PR_BITS-1:0] old0;
  logic [PR_BITS-1:0] old1;
  logic [1:0]         free_valid_nxt;
  logic [1:0][PR_BITS-1:0] free_prn_nxt;
  logic [1:0]         mp_nxt;

  always_comb begin
    // A younger same-thread slot behind a mispredicted branch is wrong-path.
    kill1     = commit_valid[0] && commit_mispredict[0] &&
                (commit_thread_id[0] == commit_thread_id[1]);
    live[0]   = commit_valid[0];
    live[1]   = commit_valid[1] && !kill1;
    eff[0]    = live[0] && (commit_ARN_dest[0] != ZERO_AR) && (commit_PRN_dest[0] != NO_PRN);
    eff[1]    = live[1] && (commit_ARN_dest[1] != ZERO_AR) && (commit_PRN_dest[1] != NO_PRN);
    same_dest = (commit_thread_id[0] == commit_thread_id[1]) &&
                (commit_ARN_dest[0] == commit_ARN_dest[1]);

    old0 = RRAT_arr[commit_thread_id[0]][commit_ARN_dest[0]];
    // Slot 1 overwrites what slot 0 just wrote when both target the same entry.
    if (eff[0] && eff[1] && same_dest) begin
      old1 = commit_PRN_dest[0];
    end else begin
      old1 = RRAT_arr[commit_thread_id[1]][commit_ARN_dest[1]];
    end

    free_valid_nxt[0] = eff[0] && (old0 != NO_PRN);
    free_valid_nxt[1] = eff[1] && (old1 != NO_PRN);
    free_prn_nxt[0]   = free_valid_nxt[0] ? old0 : NO_PRN;
    free_prn_nxt[1]   = free_valid_nxt[1] ? old1 : NO_PRN;

    mp_nxt[0] = (live[0] && commit_mispredict[0] && (commit_thread_id[0] == 1'b0)) ||
                (live[1] && commit_mispredict[1] && (commit_thread_id[1] == 1'b0));
    mp_nxt[1] = (live[0] && commit_mispredict[0] && (commit_thread_id[0] == 1'b1)) ||
                (live[1] && commit_mispredict[1] && (commit_thread_id[1] == 1'b1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < 2; t++) begin
        for (int a = 0; a < AR_SIZE; a++) begin
          RRAT_arr[t][a] <= NO_PRN;
        end
      end
      free_valid          <= 2'b00;
      free_PRN            <= {2{NO_PRN}};
      mispredict_thread_0 <= 1'b0;
      mispredict_thread_1 <= 1'b0;
    end else begin
      if (eff[0]) begin
        RRAT_arr[commit_thread_id[0]][commit_ARN_dest[0]] <= commit_PRN_dest[0];
      end
      if (eff[1]) begin
        RRAT_arr[commit_thread_id[1]][commit_ARN_dest[1]] <= commit_PRN_dest[1];
      end
      free_valid          <= free_valid_nxt;
      free_PRN            <= free_prn_nxt;
      mispredict_thread_0 <= mp_nxt[0];
      mispredict_thread_1 <= mp_nxt[1];
    end
  end

endmodule

// File: tb/tb_rrat.sv
// tb/tb_rrat.sv - directed and randomized model-checked bench for rrat
module tb_rrat;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           commit_valid;
  logic [1:0]           commit_thread_id;
  logic [1:0][4:0]      commit_ARN_dest;
  logic [1:0][5:0]      commit_PRN_dest;
  logic [1:0]           commit_mispredict;
  logic [1:0][31:0][5:0] RRAT_arr;
  logic [1:0]           free_valid;
  logic [1:0][5:0]      free_PRN;
  logic                 mispredict_thread_0;
  logic                 mispredict_thread_1;

  int checks = 0;
  int errors = 0;

  logic [1:0][31:0][5:0] all_none;

  rrat dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_thread_id(commit_thread_id),
    .commit_ARN_dest(commit_ARN_dest), .commit_PRN_dest(commit_PRN_dest),
    .commit_mispredict(commit_mispredict), .RRAT_arr(RRAT_arr),
    .free_valid(free_valid), .free_PRN(free_PRN),
    .mispredict_thread_0(mispredict_thread_0), .mispredict_thread_1(mispredict_thread_1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    commit_valid      = 2'b00;
    commit_thread_id  = 2'b00;
    commit_ARN_dest   = '0;
    commit_PRN_dest   = '0;
    commit_mispredict = 2'b00;
  endtask

  task automatic slot(input int i, input logic t, input logic [4:0] a,
                      input logic [5:0] p, input logic m);
    commit_valid[i]      = 1'b1;
    commit_thread_id[i]  = t;
    commit_ARN_dest[i]   = a;
    commit_PRN_dest[i]   = p;
    commit_mispredict[i] = m;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (RRAT_arr !== all_none) begin errors++; $display("FAIL reset_map got %h want all 3f", RRAT_arr); end
    checks++; if (free_valid !== 2'b00) begin errors++; $display("FAIL reset_free_valid got %b want 00", free_valid); end
    checks++; if (free_PRN !== {6'd63, 6'd63}) begin errors++; $display("FAIL reset_free_prn got %h want fff", free_PRN); end
    checks++; if ({mispredict_thread_1, mispredict_thread_0} !== 2'b00) begin errors++;
      $display("FAIL reset_mp got %b%b want 00", mispredict_thread_1, mispredict_thread_0); end
  endtask

  task automatic test_single();
    idle(); slot(0, 1'b0, 5'd3, 6'd5, 1'b0); tick();
    checks++; if (RRAT_arr[0][3] !== 6'd5) begin errors++; $display("FAIL single_map1 got %0d want 5", RRAT_arr[0][3]); end
    checks++; if (free_valid !== 2'b00) begin errors++; $display("FAIL single_fv1 got %b want 00", free_valid); end
    idle(); slot(0, 1'b0, 5'd3, 6'd9, 1'b0); tick();
    checks++; if (RRAT_arr[0][3] !== 6'd9) begin errors++; $display("FAIL single_map2 got %0d want 9", RRAT_arr[0][3]); end
    checks++; if (free_valid !== 2'b01 || free_PRN[0] !== 6'd5) begin errors++;
      $display("FAIL single_free got fv=%b prn=%0d want fv=01 prn=5", free_valid, free_PRN[0]); end
  endtask

  task automatic test_same_arn();
    idle(); slot(0, 1'b1, 5'd4, 6'd7, 1'b0); tick();
    idle(); slot(0, 1'b1, 5'd4, 6'd10, 1'b0); slot(1, 1'b1, 5'd4, 6'd11, 1'b0); tick();
    checks++; if (RRAT_arr[1][4] !== 6'd11) begin errors++; $display("FAIL same_arn_map got %0d want 11", RRAT_arr[1][4]); end
    checks++; if (free_valid !== 2'b11 || free_PRN[0] !== 6'd7 || free_PRN[1] !== 6'd10) begin errors++;
      $display("FAIL same_arn_free got fv=%b p0=%0d p1=%0d want 11/7/10", free_valid, free_PRN[0], free_PRN[1]); end
  endtask

  task automatic test_kill();
    idle(); slot(0, 1'b0, 5'd2, 6'd12, 1'b1); slot(1, 1'b0, 5'd6, 6'd13, 1'b1); tick();
    checks++; if (RRAT_arr[0][2] !== 6'd12 || RRAT_arr[0][6] !== 6'd63) begin errors++;
      $display("FAIL kill_map got a2=%0d a6=%0d want 12/63", RRAT_arr[0][2], RRAT_arr[0][6]); end
    checks++; if ({mispredict_thread_1, mispredict_thread_0} !== 2'b01) begin errors++;
      $display("FAIL kill_mp got %b%b want 01", mispredict_thread_1, mispredict_thread_0); end
    checks++; if (free_valid !== 2'b00) begin errors++; $display("FAIL kill_fv got %b want 00", free_valid); end
    idle(); tick();
    checks++; if (mispredict_thread_0 !== 1'b0) begin errors++; $display("FAIL kill_pulse_len got %b want 0", mispredict_thread_0); end
  endtask

  task automatic test_cross_thread();
    idle(); slot(0, 1'b0, 5'd1, 6'd14, 1'b1); slot(1, 1'b1, 5'd1, 6'd15, 1'b0); tick();
    checks++; if (RRAT_arr[0][1] !== 6'd14 || RRAT_arr[1][1] !== 6'd15) begin errors++;
      $display("FAIL cross_map got %0d/%0d want 14/15", RRAT_arr[0][1], RRAT_arr[1][1]); end
    checks++; if ({mispredict_thread_1, mispredict_thread_0} !== 2'b01) begin errors++;
      $display("FAIL cross_mp got %b%b want 01", mispredict_thread_1, mispredict_thread_0); end
    idle(); tick();
  endtask

  task automatic test_zero_reg();
    idle(); slot(0, 1'b0, 5'd31, 6'd20, 1'b0); tick();
    checks++; if (RRAT_arr[0][31] !== 6'd63 || free_valid !== 2'b00) begin errors++;
      $display("FAIL zero_reg got map=%0d fv=%b want 63/00", RRAT_arr[0][31], free_valid); end
    idle(); slot(1, 1'b1, 5'd31, 6'd21, 1'b1); tick();
    checks++; if (RRAT_arr[1][31] !== 6'd63 || mispredict_thread_1 !== 1'b1) begin errors++;
      $display("FAIL zero_reg_mp got map=%0d mp1=%b want 63/1", RRAT_arr[1][31], mispredict_thread_1); end
    idle(); commit_mispredict = 2'b11; commit_thread_id = 2'b10; tick();
    checks++; if ({mispredict_thread_1, mispredict_thread_0} !== 2'b00) begin errors++;
      $display("FAIL invalid_mp got %b%b want 00", mispredict_thread_1, mispredict_thread_0); end
  endtask

  task automatic test_reset_commit();
    idle(); slot(0, 1'b0, 5'd3, 6'd40, 1'b1); reset = 1'b1; tick();
    reset = 1'b0; idle();
    checks++; if (RRAT_arr !== all_none || free_valid !== 2'b00 || mispredict_thread_0 !== 1'b0) begin errors++;
      $display("FAIL reset_commit got fv=%b mp0=%b map03=%0d want 00/0/63", free_valid, mispredict_thread_0, RRAT_arr[0][3]); end
    tick();
  endtask

  task automatic test_random();
    int map [2][32];
    logic [1:0][31:0][5:0] exp_arr;
    logic [1:0] exp_fv;
    logic [1:0][5:0] exp_fp;
    logic [1:0] exp_mp;
    bit killed;
    for (int t = 0; t < 2; t++) for (int a = 0; a < 32; a++) map[t][a] = 63;
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) != 0)
          slot(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
               ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 62)),
               1'($urandom_range(0, 4) == 0));
        else commit_mispredict[i] = 1'($urandom_range(0, 1));
      end
      // Retire in program order; a mispredicting older slot discards younger same-thread work.
      exp_fv = 2'b00; exp_fp = {6'd63, 6'd63}; exp_mp = 2'b00; killed = 0;
      for (int i = 0; i < 2; i++) begin
        int t, a, p;
        t = commit_thread_id[i]; a = commit_ARN_dest[i]; p = commit_PRN_dest[i];
        if (!commit_valid[i] || killed) continue;
        if (commit_mispredict[i]) begin
          exp_mp[t] = 1'b1;
          if (i == 0 && commit_valid[1] && commit_thread_id[1] == commit_thread_id[0]) killed = 1;
        end
        if (a != 31 && p != 63) begin
          if (map[t][a] != 63) begin exp_fv[i] = 1'b1; exp_fp[i] = 6'(map[t][a]); end
          map[t][a] = p;
        end
      end
      tick();
      for (int t = 0; t < 2; t++) for (int a = 0; a < 32; a++) exp_arr[t][a] = 6'(map[t][a]);
      checks++; if (RRAT_arr !== exp_arr) begin errors++; $display("FAIL rand_map cycle %0d got %h want %h", n, RRAT_arr, exp_arr); end
      checks++; if (free_valid !== exp_fv || free_PRN !== exp_fp) begin errors++;
        $display("FAIL rand_free cycle %0d got fv=%b prn=%h want fv=%b prn=%h", n, free_valid, free_PRN, exp_fv, exp_fp); end
      checks++; if ({mispredict_thread_1, mispredict_thread_0} !== exp_mp) begin errors++;
        $display("FAIL rand_mp cycle %0d got %b%b want %b", n, mispredict_thread_1, mispredict_thread_0, exp_mp); end
    end
  endtask

  initial begin
    all_none = {64{6'd63}};
    reset = 1'b1;
    idle();
    test_reset();
    test_single();
    test_same_arn();
    test_kill();
    test_cross_thread();
    test_zero_reg();
    test_reset_commit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rrat.md
Name: rrat

Overview:
Retirement RAT: the commit-side counterpart of the dispatch-side RAT. It holds the architected ARN->PRN mapping for two threads and updates on in-order commit of up to two instructions per cycle. It releases each overwritten PRN back to the PRF free list. It drives the RRAT copy and registered per-thread mispredict pulses that the RAT uses to restore its speculative map.

Parameters:
AR_SIZE, 32, architectural registers per thread
PR_SIZE, 64, physical registers; PR_SIZE-1 is the "no register" PRN
PR_BITS, 6, log2(PR_SIZE)
ZERO_REG, 31, hardwired-zero ARN; commits to it never change state

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
commit_valid  input  [1:0]  slot i retiring this cycle; slot 0 older than slot 1
commit_thread_id  input  [1:0]  thread of slot i
commit_ARN_dest  input  [1:0][4:0]  destination ARN of slot i
commit_PRN_dest  input  [1:0][PR_BITS-1:0]  destination PRN of slot i
commit_mispredict  input  [1:0]  slot i is a mispredicted branch
RRAT_arr  output  [1:0][AR_SIZE-1:0][PR_BITS-1:0]  architected map per thread, registered
free_valid  output  [1:0]  free_PRN[i] released this cycle, registered
free_PRN  output  [1:0][PR_BITS-1:0]  PRN returned to the free list
mispredict_thread_0  output  1  registered one-cycle recovery pulse, thread 0
mispredict_thread_1  output  1  registered one-cycle recovery pulse, thread 1

Behaviour:
- Reset (sync, active-high) sets:
  - every RRAT_arr entry of both threads to PR_SIZE-1
  - free_valid=0, free_PRN=PR_SIZE-1, both mispredict pulses=0
  - reset has priority over any same-cycle commit
- Effective commit:
  - eff0 = commit_valid[0] && ARN_dest[0]!=ZERO_REG && PRN_dest[0]!=PR_SIZE-1
  - kill1 = commit_valid[0] && commit_mispredict[0] && thread_id[0]==thread_id[1]; a same-thread younger slot behind a mispredicted branch is wrong-path and is discarded entirely, including its mispredict flag
  - eff1 = commit_valid[1] && !kill1 && ARN/PRN conditions as for slot 0
- Map update (visible on RRAT_arr one cycle after commit):
  - slot 0 applied first, then slot 1
  - slot 1 wins on same thread + same ARN
- Released PRN:
  - old0 = RRAT_arr[t0][a0] before the update
  - old1 = P0 (slot 0's new PRN) if eff0 && eff1 && same thread && same ARN, else RRAT_arr[t1][a1] before the update
  - free_valid[i] = eff_i && old_i!=PR_SIZE-1, registered: 1-cycle latency
  - free_PRN[i] = old_i when free_valid[i], else PR_SIZE-1
- Mispredict:
  - mispredict_thread_t is set the next cycle if any non-killed valid slot of thread t has commit_mispredict
  - the pulse lasts exactly one cycle
  - it coincides with RRAT_arr already including that cycle's commits, so the RAT copies a consistent map
  - a slot with valid=0 never triggers anything
- Threads are independent: slot 0 on thread 0 mispredicting does not block slot 1 on thread 1.
- Retirement to ZERO_REG with a valid mispredict still raises the pulse, but does not change the map.
- No stall or backpressure; the PRF must accept two frees per cycle.

Test Plan:
- Reset, then idle → all RRAT_arr entries=63, free_valid=00, mispredict pulses 0.
- Slot 0 {t0, ARN 3, PRN 5} → next cycle RRAT_arr[0][3]=5, free_valid=00 (old=63). Then slot 0 {t0, ARN 3, PRN 9} → RRAT_arr[0][3]=9, free_valid[0]=1, free_PRN[0]=5.
- Same cycle, slot 0 {t1, ARN 4, PRN 10} and slot 1 {t1, ARN 4, PRN 11}, prior map 7 → RRAT_arr[1][4]=11; free_PRN[0]=7, free_PRN[1]=10, both valid.
- Slot 0 {t0, ARN 2, PRN 12, mispredict} and slot 1 {t0, ARN 6, PRN 13} → RRAT_arr[0][2]=12, RRAT_arr[0][6] unchanged, mispredict_thread_0=1 for exactly one cycle, free_valid[1]=0.
- Slot 0 {t0 mispredict, ARN 1, PRN 14} and slot 1 {t1, ARN 1, PRN 15} → both maps updated, only mispredict_thread_0 pulses.
- Commit to ARN 31 with PRN 20 → no map change, free_valid=00. Assert reset together with a valid commit → all entries 63, no free and no pulse the next cycle.
